// File: rtl/retire_trace_buffer.sv
// Retirement trace capture buffer.
// Each retired instruction is stored as {cycle stamp, pc, instruction word}.
// MODE 0 is a FIFO that drops new entries when full. MODE 1 is a wrap-around
// history that overwrites the oldest entry and can be frozen by trig.
// Capture stops after a halt instruction has been recorded.
module retire_trace_buffer #(
  parameter int                 ADDR_W     = 32,
  parameter int                 INSTR_W    = 32,
  parameter int                 CNT_W      = 32,
  parameter int                 DEPTH      = 16,
  parameter int                 MODE       = 0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 32'h00100073
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     ret_valid,
  input  logic [ADDR_W-1:0]        ret_pc,
  input  logic [INSTR_W-1:0]       ret_instr,
  input  logic                     trig,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [CNT_W-1:0]         rd_cycle,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [INSTR_W-1:0]       rd_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         cycle,
  output logic                     overflow,
  output logic                     frozen,
  output logic                     halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);

  // Entry storage; deliberately not reset, only pointers and flags are.
  logic [CNT_W-1:0]   mem_cycle [DEPTH];
  logic [ADDR_W-1:0]  mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic full;
  logic capture;
  logic pop;
  logic drop;
  logic overwrite;
  logic do_write;
  logic rd_adv;

  // Show-ahead read port: head entry is presented straight from storage.
  assign rd_valid = (count != '0);
  assign rd_cycle = mem_cycle[rd_ptr];
  assign rd_pc    = mem_pc[rd_ptr];
  assign rd_instr = mem_instr[rd_ptr];

  // Decode this cycle's capture/pop actions; clear suppresses both.
  always_comb begin
    full      = (count == OCC_FULL);
    capture   = en && ret_valid && !frozen && !halted && !clear;
    pop       = rd_valid && rd_ready && !clear;
    // A pop while full frees a slot, so the new entry never needs to be
    // dropped or to displace the head in that case.
    drop      = capture && full && !pop && (MODE == 0);
    overwrite = capture && full && !pop && (MODE != 0);
    do_write  = capture && !drop;
    // When full in wrap mode wr_ptr equals rd_ptr, so overwriting means
    // the read pointer must step past the slot being replaced.
    rd_adv    = pop || overwrite;
  end

  // Free-running cycle stamp, gated only by en and unaffected by clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle <= '0;
    end else if (en) begin
      cycle <= cycle + CYC_ONE;
    end
  end

  // Entry write; stamp is the counter value before this edge's increment.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_cycle[wr_ptr] <= cycle;
      mem_pc[wr_ptr]    <= ret_pc;
      mem_instr[wr_ptr] <= ret_instr;
    end
  end

  // Pointers, occupancy and sticky status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      frozen   <= 1'b0;
      halted   <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      frozen   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_write && !rd_adv) begin
        count <= count + OCC_ONE;
      end else if (!do_write && rd_adv) begin
        count <= count - OCC_ONE;
      end
      if (drop || overwrite) begin
        overflow <= 1'b1;
      end
      if ((MODE != 0) && trig) begin
        frozen <= 1'b1;
      end
      // The halt instruction itself counts as captured before capture stops.
      if (capture && (ret_instr == HALT_INSTR)) begin
        halted <= 1'b1;
      end
    end
  end

endmodule
